// File: rtl/data_table_delete_pkg.sv
// rtl/data_table_delete_pkg.sv - hash table types shared by the delete engine and its buses
package data_table_delete_pkg;

  localparam int KEY_WIDTH        = 16;
  localparam int VALUE_WIDTH      = 16;
  localparam int BUCKET_WIDTH     = 8;
  localparam int TABLE_ADDR_WIDTH = 8;
  localparam int RAM_LATENCY      = 2;

  typedef struct packed {
    logic [KEY_WIDTH-1:0]   key;
    logic [VALUE_WIDTH-1:0] value;
  } ht_command_t;

  typedef struct packed {
    ht_command_t                 cmd;
    logic [BUCKET_WIDTH-1:0]     bucket;
    logic [TABLE_ADDR_WIDTH-1:0] head_ptr;
    logic                        head_ptr_val;
  } ht_pdata_t;

  typedef struct packed {
    ht_command_t             cmd;
    logic [BUCKET_WIDTH-1:0] bucket;
  } ht_locked_task_t;

  typedef struct packed {
    logic [KEY_WIDTH-1:0]        key;
    logic [VALUE_WIDTH-1:0]      value;
    logic [TABLE_ADDR_WIDTH-1:0] next_ptr;
    logic                        next_ptr_val;
  } ram_data_t;

  typedef enum logic [2:0] {
    SEARCH_FOUND,
    SEARCH_NOT_SUCCESS_NO_ENTRY,
    INSERT_SUCCESS,
    INSERT_SUCCESS_SAME_KEY,
    INSERT_NOT_SUCCESS_TABLE_IS_FULL,
    DELETE_SUCCESS,
    DELETE_NOT_SUCCESS_NO_ENTRY
  } ht_rescode_t;

  typedef enum logic [1:0] {
    NO_CHAIN,
    IN_HEAD,
    IN_MIDDLE,
    IN_TAIL
  } ht_chain_state_t;

  typedef struct packed {
    ht_command_t             cmd;
    ht_rescode_t             rescode;
    logic [BUCKET_WIDTH-1:0] bucket;
    logic [VALUE_WIDTH-1:0]  found_value;
    ht_chain_state_t         chain_state;
  } ht_result_t;

  // Predecessor keeps its own key/value but inherits the removed node's link.
  function automatic ram_data_t relink(input ram_data_t prev,
                                       input logic [TABLE_ADDR_WIDTH-1:0] next_ptr,
                                       input logic next_ptr_val);
    ram_data_t r;
    r              = prev;
    r.next_ptr     = next_ptr;
    r.next_ptr_val = next_ptr_val;
    return r;
  endfunction

endpackage

// File: rtl/data_table_delete_if.sv
// rtl/data_table_delete_if.sv - data RAM, head table and result buses
interface data_table_bus_if;
  import data_table_delete_pkg::*;
  logic                        rd_en;
  logic [TABLE_ADDR_WIDTH-1:0] rd_addr;
  ram_data_t                   rd_data;
  logic                        wr_en;
  logic [TABLE_ADDR_WIDTH-1:0] wr_addr;
  ram_data_t                   wr_data;

  modport master (output rd_en, rd_addr, wr_en, wr_addr, wr_data, input rd_data);
  modport slave  (input rd_en, rd_addr, wr_en, wr_addr, wr_data, output rd_data);
endinterface

interface head_table_bus_if;
  import data_table_delete_pkg::*;
  logic                        wr_en;
  logic [BUCKET_WIDTH-1:0]     wr_addr;
  logic [TABLE_ADDR_WIDTH-1:0] wr_data_ptr;
  logic                        wr_data_ptr_val;

  modport master (output wr_en, wr_addr, wr_data_ptr, wr_data_ptr_val);
  modport slave  (input wr_en, wr_addr, wr_data_ptr, wr_data_ptr_val);
endinterface

interface ht_res_bus_if;
  import data_table_delete_pkg::*;
  ht_result_t result;
  logic       valid;
  logic       ready;

  modport master (output result, valid, input ready);
  modport slave  (input result, valid, output ready);
endinterface

// File: rtl/data_table_delete_rd_data_val.sv
// rtl/data_table_delete_rd_data_val.sv - delays a read strobe by the RAM read latency
module rd_data_val_helper #(
  parameter int RAM_LATENCY = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic rd_en_i,
  output logic rd_data_val_o
);

  logic [RAM_LATENCY-1:0] pipe_q;

  generate
    if (RAM_LATENCY == 1) begin : g_single
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) pipe_q <= '0;
        else       pipe_q <= rd_en_i;
      end
    end else begin : g_shift
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) pipe_q <= '0;
        else       pipe_q <= {pipe_q[RAM_LATENCY-2:0], rd_en_i};
      end
    end
  endgenerate

  assign rd_data_val_o = pipe_q[RAM_LATENCY-1];

endmodule

// File: rtl/data_table_delete.sv
// rtl/data_table_delete.sv - walks a bucket chain, unlinks the node holding the key and frees it
module data_table_delete
  import data_table_delete_pkg::*;
#(
  parameter int RAM_LATENCY = 2,
  parameter int A_WIDTH     = TABLE_ADDR_WIDTH
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  ht_pdata_t              task_i,
  input  logic                   task_valid_i,
  output logic                   task_ready_o,
  data_table_bus_if.master       data_table_if,
  output logic [A_WIDTH-1:0]     empty_addr_o,
  output logic                   empty_addr_add_o,
  head_table_bus_if.master       head_table_if,
  ht_res_bus_if.master           ht_res_if
);

  typedef enum logic [2:0] {
    IDLE_S,
    READ_HEAD_S,
    GO_ON_CHAIN_S,
    UPD_HEAD_S,
    UPD_PREV_S,
    NO_ENTRY_S
  } state_t;

  state_t                    state_q, state_d;
  logic                      first_q, first_d;
  ht_locked_task_t           task_locked_q, task_locked_d;
  logic [A_WIDTH-1:0]        rd_addr_q, rd_addr_d;
  logic [A_WIDTH-1:0]        prev_addr_q, prev_addr_d;
  ram_data_t                 prev_data_q, prev_data_d;
  logic [VALUE_WIDTH-1:0]    match_value_q, match_value_d;
  logic [A_WIDTH-1:0]        match_ptr_q, match_ptr_d;
  logic                      match_ptr_val_q, match_ptr_val_d;
  logic                      rd_data_val;
  logic                      key_match;
  ram_data_t                 rd_data;

  rd_data_val_helper #(.RAM_LATENCY(RAM_LATENCY)) u_rd_data_val (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .rd_en_i       (data_table_if.rd_en),
    .rd_data_val_o (rd_data_val)
  );

  assign rd_data   = data_table_if.rd_data;
  assign key_match = (rd_data.key == task_locked_q.cmd.key);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q         <= IDLE_S;
      first_q         <= 1'b0;
      task_locked_q   <= '0;
      rd_addr_q       <= '0;
      prev_addr_q     <= '0;
      prev_data_q     <= '0;
      match_value_q   <= '0;
      match_ptr_q     <= '0;
      match_ptr_val_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      first_q         <= first_d;
      task_locked_q   <= task_locked_d;
      rd_addr_q       <= rd_addr_d;
      prev_addr_q     <= prev_addr_d;
      prev_data_q     <= prev_data_d;
      match_value_q   <= match_value_d;
      match_ptr_q     <= match_ptr_d;
      match_ptr_val_q <= match_ptr_val_d;
    end
  end

  // first_d marks the first cycle of a state; strobes are gated by it so a
  // stalled result never repeats a write or free.
  always_comb begin
    state_d         = state_q;
    first_d         = 1'b0;
    task_locked_d   = task_locked_q;
    rd_addr_d       = rd_addr_q;
    prev_addr_d     = prev_addr_q;
    prev_data_d     = prev_data_q;
    match_value_d   = match_value_q;
    match_ptr_d     = match_ptr_q;
    match_ptr_val_d = match_ptr_val_q;
    unique case (state_q)
      IDLE_S: begin
        if (task_valid_i) begin
          task_locked_d.cmd    = task_i.cmd;
          task_locked_d.bucket = task_i.bucket;
          rd_addr_d            = task_i.head_ptr;
          first_d              = 1'b1;
          state_d              = task_i.head_ptr_val ? READ_HEAD_S : NO_ENTRY_S;
        end
      end
      READ_HEAD_S, GO_ON_CHAIN_S: begin
        if (rd_data_val) begin
          first_d = 1'b1;
          if (key_match) begin
            match_value_d   = rd_data.value;
            match_ptr_d     = rd_data.next_ptr;
            match_ptr_val_d = rd_data.next_ptr_val;
            state_d         = (state_q == READ_HEAD_S) ? UPD_HEAD_S : UPD_PREV_S;
          end else if (!rd_data.next_ptr_val) begin
            state_d = NO_ENTRY_S;
          end else begin
            prev_addr_d = rd_addr_q;
            prev_data_d = rd_data;
            rd_addr_d   = rd_data.next_ptr;
            state_d     = GO_ON_CHAIN_S;
          end
        end
      end
      UPD_HEAD_S, UPD_PREV_S, NO_ENTRY_S: begin
        if (ht_res_if.ready) state_d = IDLE_S;
      end
      default: state_d = IDLE_S;
    endcase
  end

  assign task_ready_o = (state_q == IDLE_S);

  assign data_table_if.rd_en   = first_q && (state_q == READ_HEAD_S || state_q == GO_ON_CHAIN_S);
  assign data_table_if.rd_addr = rd_addr_q;
  assign data_table_if.wr_en   = first_q && (state_q == UPD_PREV_S);
  assign data_table_if.wr_addr = prev_addr_q;
  assign data_table_if.wr_data = relink(prev_data_q, match_ptr_q, match_ptr_val_q);

  assign head_table_if.wr_en           = first_q && (state_q == UPD_HEAD_S);
  assign head_table_if.wr_addr         = task_locked_q.bucket;
  assign head_table_if.wr_data_ptr     = match_ptr_q;
  assign head_table_if.wr_data_ptr_val = match_ptr_val_q;

  assign empty_addr_o     = rd_addr_q;
  assign empty_addr_add_o = first_q && (state_q == UPD_HEAD_S || state_q == UPD_PREV_S);

  assign ht_res_if.valid = (state_q == UPD_HEAD_S) || (state_q == UPD_PREV_S) ||
                           (state_q == NO_ENTRY_S);

  always_comb begin
    ht_res_if.result        = '0;
    ht_res_if.result.cmd    = task_locked_q.cmd;
    ht_res_if.result.bucket = task_locked_q.bucket;
    unique case (state_q)
      UPD_HEAD_S: begin
        ht_res_if.result.rescode     = DELETE_SUCCESS;
        ht_res_if.result.found_value = match_value_q;
        ht_res_if.result.chain_state = IN_HEAD;
      end
      UPD_PREV_S: begin
        ht_res_if.result.rescode     = DELETE_SUCCESS;
        ht_res_if.result.found_value = match_value_q;
        ht_res_if.result.chain_state = match_ptr_val_q ? IN_MIDDLE : IN_TAIL;
      end
      NO_ENTRY_S: begin
        ht_res_if.result.rescode     = DELETE_NOT_SUCCESS_NO_ENTRY;
        ht_res_if.result.chain_state = NO_CHAIN;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_data_table_delete.sv
// tb/tb_data_table_delete.sv - scoreboard bench for the delete engine with a list-level chain model
module tb_data_table_delete;
  import data_table_delete_pkg::*;

  typedef struct {
    ht_result_t                  res;
    int                          reads;
    int                          lat;
    bit                          hw;
    logic [BUCKET_WIDTH-1:0]     hw_addr;
    logic [TABLE_ADDR_WIDTH-1:0] hw_ptr;
    logic                        hw_val;
    bit                          dw;
    logic [TABLE_ADDR_WIDTH-1:0] dw_addr;
    ram_data_t                   dw_data;
    bit                          fr;
    logic [TABLE_ADDR_WIDTH-1:0] fr_addr;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ht_pdata_t                   task_in;
  logic                        task_valid;
  logic                        task_ready;
  logic [TABLE_ADDR_WIDTH-1:0] empty_addr;
  logic                        empty_add;

  data_table_bus_if dt_if ();
  head_table_bus_if hd_if ();
  ht_res_bus_if     res_if ();

  data_table_delete #(.RAM_LATENCY(RAM_LATENCY), .A_WIDTH(TABLE_ADDR_WIDTH)) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .task_i           (task_in),
    .task_valid_i     (task_valid),
    .task_ready_o     (task_ready),
    .data_table_if    (dt_if),
    .empty_addr_o     (empty_addr),
    .empty_addr_add_o (empty_add),
    .head_table_if    (hd_if),
    .ht_res_if        (res_if)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Data RAM model: two-stage read pipeline, junk when no read was issued.
  ram_data_t mem [256];
  ram_data_t rd_p1, rd_p2;

  function automatic ram_data_t rnd_node();
    ram_data_t n;
    n.key          = 16'($urandom);
    n.value        = 16'($urandom);
    n.next_ptr     = 8'($urandom);
    n.next_ptr_val = 1'($urandom);
    return n;
  endfunction

  always @(posedge clk) begin
    rd_p1 <= dt_if.rd_en ? mem[dt_if.rd_addr] : rnd_node();
    rd_p2 <= rd_p1;
  end
  assign dt_if.rd_data = rd_p2;

  int hold_left = 0;
  bit bp_en = 1'b0;
  initial begin
    res_if.ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (hold_left > 0 && res_if.valid) begin
        res_if.ready = 1'b0;
        hold_left--;
      end else begin
        res_if.ready = bp_en ? 1'($urandom) : 1'b1;
      end
    end
  end

  // Monitor: strobe bookkeeping per task and result checking against the queue.
  exp_t exp_q [$];
  exp_t me;
  int cyc = 0, acc_cyc = 0, lat = 0;
  bit seen_valid = 1'b0, holding = 1'b0;
  int n_rd = 0, n_wr = 0, n_hw = 0, n_fr = 0;
  logic [TABLE_ADDR_WIDTH-1:0] wr_a, hw_p, fr_a;
  logic [BUCKET_WIDTH-1:0]     hw_a;
  logic                        hw_v;
  ram_data_t                   wr_d;
  ht_result_t                  held;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      holding = 1'b0;
    end else begin
      if (task_valid && task_ready) begin
        acc_cyc = cyc; n_rd = 0; n_wr = 0; n_hw = 0; n_fr = 0;
        seen_valid = 1'b0; holding = 1'b0;
      end else begin
        if (dt_if.rd_en) n_rd++;
        if (dt_if.wr_en) begin n_wr++; wr_a = dt_if.wr_addr; wr_d = dt_if.wr_data; end
        if (hd_if.wr_en) begin
          n_hw++; hw_a = hd_if.wr_addr; hw_p = hd_if.wr_data_ptr; hw_v = hd_if.wr_data_ptr_val;
        end
        if (empty_add) begin n_fr++; fr_a = empty_addr; end
      end
      if (res_if.valid) begin
        if (!seen_valid) begin seen_valid = 1'b1; lat = cyc - acc_cyc; end
        if (holding) chk("result_stable", 128'(res_if.result), 128'(held));
        if (res_if.ready) begin
          holding = 1'b0;
          if (exp_q.size() == 0) begin
            chk("unexpected_result", 128'(res_if.valid), 128'(0));
          end else begin
            me = exp_q.pop_front();
            chk("result", 128'(res_if.result), 128'(me.res));
            chk("latency", 128'(lat), 128'(me.lat));
            chk("reads", 128'(n_rd), 128'(me.reads));
            chk("head_wr_count", 128'(n_hw), 128'(me.hw));
            chk("data_wr_count", 128'(n_wr), 128'(me.dw));
            chk("free_count", 128'(n_fr), 128'(me.fr));
            if (me.hw) chk("head_wr", 128'({hw_a, hw_p, hw_v}), 128'({me.hw_addr, me.hw_ptr, me.hw_val}));
            if (me.dw) chk("data_wr", 128'({wr_a, wr_d}), 128'({me.dw_addr, me.dw_data}));
            if (me.fr) chk("free_addr", 128'(fr_a), 128'(me.fr_addr));
          end
        end else begin
          holding = 1'b1;
          held = res_if.result;
        end
      end
    end
  end

  // Chain description: addresses head-first and the key stored at each.
  logic [7:0]  ch_addr [$];
  logic [15:0] ch_key [$];
  logic [15:0] absent_key;
  logic [7:0]  dir_addr [3] = '{8'd5, 8'd9, 8'd12};

  task automatic build_chain(input int n, input bit directed);
    logic [7:0]  base = 8'($urandom);
    logic [7:0]  step = 8'($urandom) | 8'd1;
    logic [15:0] kb   = 16'($urandom);
    logic [15:0] ks   = 16'($urandom) | 16'd1;
    ch_addr.delete();
    ch_key.delete();
    for (int i = 0; i < n; i++) begin
      ch_addr.push_back(directed ? dir_addr[i] : 8'(base + 8'(i) * step));
      ch_key.push_back(16'(kb + 16'(i) * ks));
    end
    absent_key = 16'(kb + 16'(n) * ks);
  endtask

  // Loads the chain into RAM and derives the outcome of deleting node tgt (-1: absent).
  task automatic prep_case(input int tgt, output ht_pdata_t t, output exp_t e);
    int n = ch_addr.size();
    ram_data_t hit;
    for (int i = 0; i < n; i++) begin
      mem[ch_addr[i]]              = rnd_node();
      mem[ch_addr[i]].key          = ch_key[i];
      mem[ch_addr[i]].next_ptr_val = (i < n - 1);
      if (i < n - 1) mem[ch_addr[i]].next_ptr = ch_addr[i + 1];
    end
    t.cmd.key      = (tgt >= 0) ? ch_key[tgt] : absent_key;
    t.cmd.value    = 16'($urandom);
    t.bucket       = 8'($urandom);
    t.head_ptr     = (n > 0) ? ch_addr[0] : 8'($urandom);
    t.head_ptr_val = (n > 0);

    e.res.cmd = t.cmd; e.res.bucket = t.bucket;
    e.hw = 1'b0; e.hw_addr = '0; e.hw_ptr = '0; e.hw_val = 1'b0;
    e.dw = 1'b0; e.dw_addr = '0; e.dw_data = '0;
    e.fr = 1'b0; e.fr_addr = '0;
    if (tgt < 0) begin
      e.res.rescode     = DELETE_NOT_SUCCESS_NO_ENTRY;
      e.res.found_value = '0;
      e.res.chain_state = NO_CHAIN;
      e.reads           = n;
    end else begin
      hit               = mem[ch_addr[tgt]];
      e.res.rescode     = DELETE_SUCCESS;
      e.res.found_value = hit.value;
      e.reads           = tgt + 1;
      e.fr              = 1'b1;
      e.fr_addr         = ch_addr[tgt];
      if (tgt == 0) begin
        e.hw = 1'b1; e.hw_addr = t.bucket; e.hw_ptr = hit.next_ptr; e.hw_val = hit.next_ptr_val;
        e.res.chain_state = IN_HEAD;
      end else begin
        e.dw                   = 1'b1;
        e.dw_addr              = ch_addr[tgt - 1];
        e.dw_data              = mem[ch_addr[tgt - 1]];
        e.dw_data.next_ptr     = hit.next_ptr;
        e.dw_data.next_ptr_val = hit.next_ptr_val;
        e.res.chain_state      = (tgt == n - 1) ? IN_TAIL : IN_MIDDLE;
      end
    end
    e.lat = e.reads * (RAM_LATENCY + 1) + 1;
  endtask

  task automatic issue(input ht_pdata_t t);
    @(posedge clk);
    #1;
    task_in    = t;
    task_valid = 1'b1;
    @(posedge clk);
    #1;
    task_valid = 1'b0;
  endtask

  task automatic run_case(input int tgt, input int hold);
    ht_pdata_t t;
    exp_t      e;
    int        guard = 0;
    prep_case(tgt, t, e);
    hold_left = hold;
    exp_q.push_back(e);
    issue(t);
    while (exp_q.size() != 0 && guard < 400) begin
      @(posedge clk);
      guard++;
    end
    chk("done_in_bound", 128'(exp_q.size()), 128'(0));
    exp_q.delete();
  endtask

  initial begin
    ht_pdata_t t;
    exp_t      e;
    int        quiet;
    task_valid = 1'b0;
    task_in    = '0;
    repeat (3) @(negedge clk);
    chk("rst_task_ready", 128'(task_ready), 128'(1));
    chk("rst_strobes", 128'({dt_if.rd_en, dt_if.wr_en, hd_if.wr_en, empty_add}), 128'(0));
    chk("rst_res_valid", 128'(res_if.valid), 128'(0));
    @(posedge clk);
    #1 rst = 1'b0;

    build_chain(0, 1'b1); run_case(-1, 0);
    build_chain(1, 1'b1); run_case(0, 0);
    build_chain(3, 1'b1); run_case(1, 0);
    build_chain(3, 1'b1); run_case(2, 0);
    build_chain(2, 1'b1); run_case(-1, 0);
    build_chain(3, 1'b1); run_case(1, 10);

    bp_en = 1'b1;
    for (int k = 0; k < 60; k++) begin
      int n = int'($urandom_range(0, 5));
      build_chain(n, 1'b0);
      run_case(int'($urandom_range(0, n)) - 1, (k % 7 == 0) ? 4 : 0);
    end
    bp_en = 1'b0;

    build_chain(4, 1'b0);
    prep_case(-1, t, e);
    issue(t);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("abort_task_ready", 128'(task_ready), 128'(1));
    chk("abort_strobes", 128'({dt_if.rd_en, dt_if.wr_en, hd_if.wr_en, empty_add}), 128'(0));
    chk("abort_res_valid", 128'(res_if.valid), 128'(0));
    @(posedge clk);
    #1 rst = 1'b0;
    quiet = 0;
    repeat (20) begin
      @(negedge clk);
      if (res_if.valid || dt_if.rd_en || dt_if.wr_en || hd_if.wr_en || empty_add) quiet++;
    end
    chk("abort_quiet", 128'(quiet), 128'(0));

    build_chain(3, 1'b1); run_case(0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
